// File: rtl/light_loc_ctrl.sv
// Light-location driver: turns debounced direction/home buttons into saturating
// L_LOC_X/Y/Z updates that are applied only at VGA frame boundaries.
module light_loc_ctrl #(
    parameter int   LOC_W     = 10,
    parameter int   STEP      = 4,
    parameter int   LOC_MAX   = 1023,
    parameter int   HOME_X    = 512,
    parameter int   HOME_Y    = 512,
    parameter int   HOME_Z    = 0,
    parameter int   FRAME_DIV = 1,
    parameter logic VS_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             VGA_VS,
    input  logic             btn_xp,
    input  logic             btn_xn,
    input  logic             btn_yp,
    input  logic             btn_yn,
    input  logic             btn_zp,
    input  logic             btn_zn,
    input  logic             btn_home,
    output logic [LOC_W-1:0] L_LOC_X,
    output logic [LOC_W-1:0] L_LOC_Y,
    output logic [LOC_W-1:0] L_LOC_Z,
    output logic             L_LOC_vld
);

    // state | meaning
    // IDLE  | waiting for a frame tick, accumulating sticky button presses
    // CALC  | compute next position from stickies, clear stickies
    // PUB   | new position and strobe visible on the outputs
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_PUB  = 2'd2
    } state_t;

    localparam int                     SW       = LOC_W + 2;
    localparam logic signed [SW-1:0]   LIM      = SW'(LOC_MAX);
    localparam logic signed [SW-1:0]   STEP_S   = SW'(STEP);
    localparam logic [7:0]             DIV_LAST = 8'(FRAME_DIV - 1);

    // sticky bit order: {home, zn, zp, yn, yp, xn, xp}
    localparam int B_XP = 0, B_XN = 1, B_YP = 2, B_YN = 3, B_ZP = 4, B_ZN = 5, B_HOME = 6;

    state_t           state_q, state_d;
    logic             vs_q;
    logic             fe;
    logic [7:0]       cnt_q, cnt_d;
    logic [6:0]       btn;
    logic [6:0]       sticky_q, sticky_d;
    logic [LOC_W-1:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d, loc_z_q, loc_z_d;
    logic [LOC_W-1:0] next_x, next_y, next_z;
    logic             changed;
    logic             vld_q, vld_d;
    logic             first_pub_q, first_pub_d;

    function automatic logic [LOC_W-1:0] step_axis(input logic [LOC_W-1:0] cur,
                                                   input logic inc, input logic dec);
        logic signed [SW-1:0] delta;
        logic signed [SW-1:0] sum;
        logic [LOC_W-1:0]     res;
        delta = '0;
        if (inc && !dec) delta = STEP_S;
        else if (dec && !inc) delta = -STEP_S;
        sum = $signed({2'b00, cur}) + delta;
        if (sum[SW-1]) res = '0;
        else if (sum > LIM) res = LOC_W'(LOC_MAX);
        else res = sum[LOC_W-1:0];
        return res;
    endfunction

    assign btn = {btn_home, btn_zn, btn_zp, btn_yn, btn_yp, btn_xn, btn_xp};
    assign fe  = (VGA_VS == VS_POL) && (vs_q != VS_POL);

    always_comb begin
        if (sticky_q[B_HOME]) begin
            next_x = LOC_W'(HOME_X);
            next_y = LOC_W'(HOME_Y);
            next_z = LOC_W'(HOME_Z);
        end else begin
            next_x = step_axis(loc_x_q, sticky_q[B_XP], sticky_q[B_XN]);
            next_y = step_axis(loc_y_q, sticky_q[B_YP], sticky_q[B_YN]);
            next_z = step_axis(loc_z_q, sticky_q[B_ZP], sticky_q[B_ZN]);
        end
        changed = (next_x != loc_x_q) || (next_y != loc_y_q) || (next_z != loc_z_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q | btn;
        loc_x_d     = loc_x_q;
        loc_y_d     = loc_y_q;
        loc_z_d     = loc_z_q;
        vld_d       = 1'b0;
        first_pub_d = first_pub_q;
        case (state_q)
            S_IDLE: begin
                if (fe) begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_CALC: begin
                // Outputs load on the CALC->PUB edge so they and the strobe are
                // visible during PUB, two cycles after the frame edge.
                sticky_d    = btn;
                loc_x_d     = next_x;
                loc_y_d     = next_y;
                loc_z_d     = next_z;
                vld_d       = changed || first_pub_q;
                first_pub_d = 1'b0;
                state_d     = S_PUB;
            end
            S_PUB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        vs_q <= VGA_VS;
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sticky_q    <= '0;
            loc_x_q     <= LOC_W'(HOME_X);
            loc_y_q     <= LOC_W'(HOME_Y);
            loc_z_q     <= LOC_W'(HOME_Z);
            vld_q       <= 1'b0;
            first_pub_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            loc_x_q     <= loc_x_d;
            loc_y_q     <= loc_y_d;
            loc_z_q     <= loc_z_d;
            vld_q       <= vld_d;
            first_pub_q <= first_pub_d;
        end
    end

    assign L_LOC_X   = loc_x_q;
    assign L_LOC_Y   = loc_y_q;
    assign L_LOC_Z   = loc_z_q;
    assign L_LOC_vld = vld_q;

endmodule
